// File: rtl/game_pkg.sv
// Shared types and helpers for the match sequencer and its ball-type LFSR.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        MATCH_OVER = 2'd3
    } state_t;

    localparam logic [1:0] BALL_PINGPONG = 2'd0;
    localparam logic [1:0] BALL_SOCCER   = 2'd1;
    localparam logic [1:0] BALL_BASKET   = 2'd2;

    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam int SERVE_CNT_W = 26;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [1:0] ball_from_lfsr(input logic [7:0] v);
        return (v[1:0] == 2'd3) ? BALL_PINGPONG : v[1:0];
    endfunction

endpackage

// File: rtl/ball_lfsr8.sv
// 8-bit Fibonacci LFSR that picks ball types; steps on request, reloads its seed on demand.
module ball_lfsr8
    import game_pkg::*;
(
    input  logic       clk_25MHZ,
    input  logic       reset_n,
    input  logic       step,
    input  logic       reload,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] lfsr_d;
    logic [7:0] lfsr_q;

    always_comb begin
        lfsr_d = lfsr_q;
        if (reload) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk_25MHZ) begin
        if (!reset_n) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/match_sequencer.sv
// Match-level sequencer: serve timing, score, lives and ball-type selection.
// Optional speed levels are enabled with `define SPEED_LEVEL_EN.
module match_sequencer
    import game_pkg::*;
#(
    parameter int unsigned SERVE_DELAY = 25_000_000,
    parameter int unsigned MAX_LIVES   = 3,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk_25MHZ,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       game_over,
    input  logic       rand_en,
    input  logic       collision_detected,
    output logic       game_start,
    output logic [1:0] rand_ball,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       match_over,
    output logic [1:0] level
);

    localparam logic [SERVE_CNT_W-1:0] DELAY_L     = SERVE_CNT_W'(SERVE_DELAY);
    localparam logic [1:0]             MAX_LIVES_L = 2'(MAX_LIVES);

    state_t                 state_d, state_q;
    logic [SERVE_CNT_W-1:0] cnt_d, cnt_q;
    logic                   game_start_d, game_start_q;
    logic [1:0]             rand_ball_d, rand_ball_q;
    logic [7:0]             score_d, score_q;
    logic [1:0]             lives_d, lives_q;
    logic                   match_over_d, match_over_q;
    logic                   go_prev_q, re_prev_q, col_prev_q;
    logic                   go_rise, re_rise, col_rise;
    logic                   lfsr_step, lfsr_reload;
    logic [7:0]             lfsr_q;
    logic [SERVE_CNT_W-1:0] reload_val;

    ball_lfsr8 u_lfsr (
        .clk_25MHZ (clk_25MHZ),
        .reset_n   (reset_n),
        .step      (lfsr_step),
        .reload    (lfsr_reload),
        .seed      (LFSR_SEED),
        .q         (lfsr_q)
    );

    assign go_rise  = game_over & ~go_prev_q;
    assign re_rise  = rand_en & ~re_prev_q;
    assign col_rise = collision_detected & ~col_prev_q;

`ifdef SPEED_LEVEL_EN
    logic [1:0]             level_d, level_q;
    logic [SERVE_CNT_W-1:0] delay_shifted;

    // Level rises every 8 rallies and caps at 3; each level halves the serve delay.
    always_comb begin
        level_d       = (score_q[7:5] != 3'd0) ? 2'd3 : score_q[4:3];
        delay_shifted = DELAY_L >> level_q;
        reload_val    = (delay_shifted == '0) ? '0 : delay_shifted - 1'b1;
    end

    always_ff @(posedge clk_25MHZ) begin
        if (!reset_n) begin
            level_q <= 2'd0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`else
    assign reload_val = DELAY_L - 1'b1;
    assign level      = 2'd0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        game_start_d = 1'b0;
        rand_ball_d  = rand_ball_q;
        score_d      = score_q;
        lives_d      = lives_q;
        lfsr_step    = 1'b0;
        lfsr_reload  = 1'b0;

        unique case (state_q)
            IDLE: begin
                score_d = 8'd0;
                lives_d = MAX_LIVES_L;
                if (btn_start) begin
                    state_d = SERVE_WAIT;
                    cnt_d   = reload_val;
                end
            end
            SERVE_WAIT: begin
                if (cnt_q == '0) begin
                    game_start_d = 1'b1;
                    state_d      = PLAY;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PLAY: begin
                if (re_rise) begin
                    lfsr_step   = 1'b1;
                    rand_ball_d = ball_from_lfsr(lfsr_next(lfsr_q));
                end
                // A lost point on the same cycle as a hit discards the hit.
                if (go_rise) begin
                    lives_d = lives_q - 1'b1;
                    if (lives_q == 2'd1) begin
                        state_d = MATCH_OVER;
                    end else begin
                        state_d = SERVE_WAIT;
                        cnt_d   = reload_val;
                    end
                end else if (col_rise && (score_q != 8'hFF)) begin
                    score_d = score_q + 1'b1;
                end
            end
            MATCH_OVER: begin
                if (btn_start) begin
                    score_d     = 8'd0;
                    lives_d     = MAX_LIVES_L;
                    lfsr_reload = 1'b1;
                    state_d     = SERVE_WAIT;
                    cnt_d       = reload_val;
                end
            end
            default: state_d = IDLE;
        endcase

        match_over_d = (state_d == MATCH_OVER);
    end

    always_ff @(posedge clk_25MHZ) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            game_start_q <= 1'b0;
            rand_ball_q  <= BALL_PINGPONG;
            score_q      <= 8'd0;
            lives_q      <= MAX_LIVES_L;
            match_over_q <= 1'b0;
            go_prev_q    <= 1'b0;
            re_prev_q    <= 1'b0;
            col_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            game_start_q <= game_start_d;
            rand_ball_q  <= rand_ball_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            match_over_q <= match_over_d;
            go_prev_q    <= game_over;
            re_prev_q    <= rand_en;
            col_prev_q   <= collision_detected;
        end
    end

    assign game_start = game_start_q;
    assign rand_ball  = rand_ball_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign match_over = match_over_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with SERVE_DELAY=10; outputs sampled on the falling edge.
module tb_match_sequencer;

    logic       clk_25MHZ = 1'b0;
    logic       reset_n;
    logic       btn_start;
    logic       game_over;
    logic       rand_en;
    logic       collision_detected;
    logic       game_start;
    logic [1:0] rand_ball;
    logic [7:0] score;
    logic [1:0] lives;
    logic       match_over;
    logic [1:0] level;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_lfsr;
    logic [1:0] exp_ball;
    logic [1:0] exp_level_sat;

    match_sequencer #(
        .SERVE_DELAY (10),
        .MAX_LIVES   (3),
        .LFSR_SEED   (8'hA5)
    ) dut (
        .clk_25MHZ          (clk_25MHZ),
        .reset_n            (reset_n),
        .btn_start          (btn_start),
        .game_over          (game_over),
        .rand_en            (rand_en),
        .collision_detected (collision_detected),
        .game_start         (game_start),
        .rand_ball          (rand_ball),
        .score              (score),
        .lives              (lives),
        .match_over         (match_over),
        .level              (level)
    );

    always #5 clk_25MHZ = ~clk_25MHZ;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference LFSR written from the tap list rather than a mask.
    function automatic logic [7:0] refStep(input logic [7:0] v);
        int taps[4] = '{8, 6, 5, 4};
        logic fb = 1'b0;
        foreach (taps[i]) fb ^= v[taps[i]-1];
        return {v[6:0], fb};
    endfunction

    function automatic logic [1:0] refBall(input logic [7:0] v);
        return (v[1:0] == 2'b11) ? 2'b00 : v[1:0];
    endfunction

    task automatic serveCheck(input string tag);
        int early = 0;
        repeat (9) begin
            @(negedge clk_25MHZ);
            if (game_start) early++;
        end
        checkOutput({tag, "_early"}, 32'(early), 32'd0);
        @(negedge clk_25MHZ);
        checkOutput({tag, "_pulse"}, 32'(game_start), 32'd1);
        @(negedge clk_25MHZ);
        checkOutput({tag, "_one_cycle"}, 32'(game_start), 32'd0);
    endtask

    task automatic hitCollision();
        collision_detected = 1'b1;
        repeat (3) @(negedge clk_25MHZ);
        collision_detected = 1'b0;
        @(negedge clk_25MHZ);
    endtask

    task automatic applyStimulus(input logic go, input logic re, input logic col);
        game_over          = go;
        rand_en            = re;
        collision_detected = col;
        @(negedge clk_25MHZ);
        game_over          = 1'b0;
        rand_en            = 1'b0;
        collision_detected = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_game_start"}, 32'(game_start), 32'd0);
        checkOutput({tag, "_rand_ball"},  32'(rand_ball),  32'd0);
        checkOutput({tag, "_score"},      32'(score),      32'd0);
        checkOutput({tag, "_lives"},      32'(lives),      32'd3);
        checkOutput({tag, "_match_over"}, 32'(match_over), 32'd0);
        checkOutput({tag, "_level"},      32'(level),      32'd0);
    endtask

    initial begin
        int cnt;
        reset_n            = 1'b0;
        btn_start          = 1'b0;
        game_over          = 1'b0;
        rand_en            = 1'b0;
        collision_detected = 1'b0;
        repeat (2) @(negedge clk_25MHZ);
        reset_n = 1'b1;
        checkResetValues("reset");

        $display("[TB] first serve");
        btn_start = 1'b1;
        @(negedge clk_25MHZ);
        btn_start = 1'b0;
        checkOutput("serve1_not_yet", 32'(game_start), 32'd0);
        serveCheck("serve1");
        checkOutput("serve1_lives", 32'(lives), 32'd3);
        checkOutput("serve1_score", 32'(score), 32'd0);

        repeat (5) hitCollision();
        checkOutput("score_five", 32'(score), 32'd5);

        ref_lfsr = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            rand_en = 1'b1;
            @(negedge clk_25MHZ);
            ref_lfsr = refStep(ref_lfsr);
            exp_ball = refBall(ref_lfsr);
            checkOutput("rand_ball_seq", 32'(rand_ball), 32'(exp_ball));
            rand_en = 1'b0;
            @(negedge clk_25MHZ);
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lost1_lives", 32'(lives), 32'd2);
        checkOutput("lost1_score", 32'(score), 32'd5);
        serveCheck("serve2");

        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("simul_score", 32'(score), 32'd5);
        checkOutput("simul_lives", 32'(lives), 32'd1);
        serveCheck("serve3");

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("final_lives", 32'(lives), 32'd0);
        checkOutput("final_match_over", 32'(match_over), 32'd1);
        cnt = 0;
        repeat (15) begin
            @(negedge clk_25MHZ);
            if (game_start) cnt++;
        end
        checkOutput("no_serve_after_match", 32'(cnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rand_ignored_idle_play", 32'(rand_ball), 32'(exp_ball));
        checkOutput("col_ignored_match_over", 32'(score), 32'd5);
        checkOutput("match_over_held", 32'(match_over), 32'd1);

        $display("[TB] restart match");
        btn_start = 1'b1;
        @(negedge clk_25MHZ);
        btn_start = 1'b0;
        checkOutput("restart_score", 32'(score), 32'd0);
        checkOutput("restart_lives", 32'(lives), 32'd3);
        checkOutput("restart_match_over", 32'(match_over), 32'd0);
        serveCheck("serve4");

        applyStimulus(1'b0, 1'b1, 1'b0);
        ref_lfsr = refStep(8'hA5);
        checkOutput("lfsr_reloaded", 32'(rand_ball), 32'(refBall(ref_lfsr)));

        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            @(negedge clk_25MHZ);
        end
        checkOutput("score_saturated", 32'(score), 32'd255);
`ifdef SPEED_LEVEL_EN
        exp_level_sat = 2'd3;
`else
        exp_level_sat = 2'd0;
`endif
        checkOutput("level_at_255", 32'(level), 32'(exp_level_sat));

        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lost_after_sat_lives", 32'(lives), 32'd2);
        @(negedge clk_25MHZ);
        reset_n = 1'b0;
        @(negedge clk_25MHZ);
        reset_n = 1'b1;
        checkResetValues("midreset");
        cnt = 0;
        repeat (15) begin
            @(negedge clk_25MHZ);
            if (game_start) cnt++;
        end
        checkOutput("no_serve_after_reset", 32'(cnt), 32'd0);

        btn_start = 1'b1;
        @(negedge clk_25MHZ);
        btn_start = 1'b0;
        serveCheck("serve5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
